// File: rtl/muldiv_sched.sv
// Round-robin scheduler sharing one signed multiplier/divider between two requesters.
// Arbitrates, launches the unit, waits for a result (with timeout) and returns it with a done pulse.
module muldiv_sched #(
    parameter int TIMEOUT = 48,
    parameter int MIN_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [63:0] b0,
    input  logic [63:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [63:0] res,
    output logic        busy,
    output logic        u_reset,
    output logic        u_start,
    output logic        u_muordi,
    output logic [31:0] u_op1,
    output logic [63:0] u_op2,
    input  logic        u_valid,
    input  logic [63:0] u_result
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err_q, err_d;
    logic [63:0]   res_q, res_d;
    logic          busy_q, busy_d;
    logic          u_reset_q, u_reset_d;
    logic          u_start_q, u_start_d;
    logic          u_muordi_q, u_muordi_d;
    logic [31:0]   u_op1_q, u_op1_d;
    logic [63:0]   u_op2_q, u_op2_d;
    logic          grant0;
    logic          grant1;

    // Handshake: a requester holds reqN high with stable operands; the scheduler
    // only looks at requests in IDLE, and the ackN pulse marks operand capture.
    // last_grant_q holds the most recent winner; a tie goes to the other side.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;
        res_d        = res_q;
        u_reset_d    = 1'b0;
        u_start_d    = 1'b0;
        u_muordi_d   = u_muordi_q;
        u_op1_d      = u_op1_q;
        u_op2_d      = u_op2_q;
        grant0       = 1'b0;
        grant1       = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant0 = req0 && (!req1 || last_grant_q);
                grant1 = req1 && (!req0 || !last_grant_q);
                if (grant0) begin
                    ack0_d       = 1'b1;
                    u_muordi_d   = op0;
                    u_op1_d      = a0;
                    u_op2_d      = b0;
                    last_grant_d = 1'b0;
                    owner_d      = 1'b0;
                    u_reset_d    = 1'b1;
                    state_d      = S_CLR;
                end else if (grant1) begin
                    ack1_d       = 1'b1;
                    u_muordi_d   = op1;
                    u_op1_d      = a1;
                    u_op2_d      = b1;
                    last_grant_d = 1'b1;
                    owner_d      = 1'b1;
                    u_reset_d    = 1'b1;
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                u_start_d = 1'b1;
                state_d   = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A stale valid from the previous operation may linger right after start.
                if ((cnt_q >= CW'(MIN_LAT)) && u_valid) begin
                    res_d   = u_result;
                    err_d   = 1'b0;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            res_q        <= '0;
            busy_q       <= 1'b0;
            u_reset_q    <= 1'b0;
            u_start_q    <= 1'b0;
            u_muordi_q   <= 1'b0;
            u_op1_q      <= '0;
            u_op2_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            res_q        <= res_d;
            busy_q       <= busy_d;
            u_reset_q    <= u_reset_d;
            u_start_q    <= u_start_d;
            u_muordi_q   <= u_muordi_d;
            u_op1_q      <= u_op1_d;
            u_op2_q      <= u_op2_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign err      = err_q;
    assign res      = res_q;
    assign busy     = busy_q;
    assign u_reset  = u_reset_q;
    assign u_start  = u_start_q;
    assign u_muordi = u_muordi_q;
    assign u_op1    = u_op1_q;
    assign u_op2    = u_op2_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with a behavioural mul/div unit and a result scoreboard.
// Expected results are queued when a request is driven and popped when a done pulse appears.
module tb_muldiv_sched;

    localparam int UNIT_LAT = 34;
    localparam int LAT_ACK_DONE = UNIT_LAT + 3;

    logic        clock;
    logic        reset;
    logic        req0, req1, op0, op1;
    logic [31:0] a0, a1;
    logic [63:0] b0, b1;
    logic        ack0, ack1, done0, done1, err, busy;
    logic [63:0] res;
    logic        u_reset, u_start, u_muordi;
    logic [31:0] u_op1;
    logic [63:0] u_op2;
    logic        u_valid;
    logic [63:0] u_result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [65:0] exp_q[$];
    logic [65:0] mon_e;

    muldiv_sched #(.TIMEOUT(48), .MIN_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .err(err), .res(res), .busy(busy),
        .u_reset(u_reset), .u_start(u_start), .u_muordi(u_muordi),
        .u_op1(u_op1), .u_op2(u_op2), .u_valid(u_valid), .u_result(u_result)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // behavioural unit: divide result is {remainder[31:0], quotient[31:0]}
    function automatic logic [63:0] unit_calc(input logic div, input logic [31:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = b;
        if (div) begin
            if (a == 32'd0) return '1;
            q = sb / sa;
            r = sb % sa;
            return {r[31:0], q[31:0]};
        end
        return sb * sa;
    endfunction

    logic        mdl_valid = 1'b0;
    logic [63:0] mdl_result = '0;
    logic [63:0] mdl_pend = '0;
    logic        mdl_run = 1'b0;
    int          mdl_cnt = 0;
    logic        stuck_mode = 1'b0;
    logic        stale_mode = 1'b0;

    always @(posedge clock) begin
        if (u_reset && !stale_mode) begin
            mdl_valid <= 1'b0;
            mdl_run   <= 1'b0;
        end else if (u_start && !stale_mode) begin
            mdl_run  <= !stuck_mode;
            mdl_cnt  <= 1;
            mdl_pend <= unit_calc(u_muordi, u_op1, u_op2);
        end else if (mdl_run) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == UNIT_LAT) begin
                mdl_valid  <= 1'b1;
                mdl_result <= mdl_pend;
                mdl_run    <= 1'b0;
            end
        end
    end

    assign u_valid  = mdl_valid;
    assign u_result = mdl_result;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (done0 || done1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", {64'd0, done1, done0}, 66'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_owner", {64'd0, done1, done0}, mon_e[65] ? 66'd2 : 66'd1);
                check("done_err", {65'd0, err}, {65'd0, mon_e[64]});
                check("done_res", {2'd0, res}, {2'd0, mon_e[63:0]});
            end
        end else if (!reset) begin
            check("err_without_done", {65'd0, err}, 66'd0);
        end
    end

    // driver helpers
    task automatic wait_for(input string tag, input int which, input int limit, output int at);
        bit hit;
        hit = 1'b0;
        at  = -1;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clock);
            case (which)
                0: hit = ack0;
                1: hit = ack1;
                2: hit = done0;
                3: hit = done1;
                4: hit = ack0 | ack1;
                default: hit = done0 | done1;
            endcase
            if (hit) at = cyc;
        end
        check({tag, "_seen"}, {65'd0, hit}, 66'd1);
    endtask

    task automatic drive_req(input int who, input logic op, input logic [31:0] a, input logic [63:0] b,
                             input logic [63:0] exp_res, input logic exp_err);
        if (who == 0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end
        exp_q.push_back({who[0], exp_err, exp_res});
    endtask

    function automatic logic [65:0] zero_outs();
        return {57'd0, ack0, ack1, done0, done1, err, busy, u_reset, u_start, u_muordi};
    endfunction

    initial begin
        int t_ack, t_done, who, gaps, dones;
        logic [31:0] ra;
        logic [63:0] rb;
        logic        rop;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        repeat (3) @(negedge clock);
        check("rst_ctrl_outs", zero_outs(), 66'd0);
        check("rst_res", {2'd0, res}, 66'd0);
        check("rst_u_ops", {2'd0, u_op1, u_op2[31:0]}, 66'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: req0 multiply 3*5
        drive_req(0, 1'b0, 32'd3, 64'd5, 64'd15, 1'b0);
        wait_for("t1_ack0", 0, 10, t_ack);
        check("t1_ureset_with_ack", {65'd0, u_reset}, 66'd1);
        check("t1_busy_at_clr", {65'd0, busy}, 66'd1);
        check("t1_u_ops", {1'b0, u_muordi, u_op1, u_op2[31:0]}, {2'b00, 32'd3, 32'd5});
        req0 = 1'b0;
        @(negedge clock);
        check("t1_ustart_next", {64'd0, u_start, u_reset}, 66'd2);
        wait_for("t1_done0", 2, 80, t_done);
        check("t1_latency", 66'(t_done - t_ack), 66'(LAT_ACK_DONE));
        @(negedge clock);

        // 2: req1 divide 100/7, busy from CLR through RESP
        drive_req(1, 1'b1, 32'd7, 64'd100, {32'd2, 32'd14}, 1'b0);
        wait_for("t2_ack1", 1, 10, t_ack);
        req1 = 1'b0;
        gaps = 0;
        dones = 0;
        if (!busy) gaps++;
        for (int i = 0; i < 80 && dones == 0; i++) begin
            @(negedge clock);
            if (!busy) gaps++;
            if (done1) dones++;
        end
        check("t2_done1_seen", 66'(dones), 66'd1);
        check("t2_busy_gaps", 66'(gaps), 66'd0);
        @(negedge clock);
        check("t2_idle_after_resp", {65'd0, busy}, 66'd0);

        // 3: both held for 4 transactions, grants alternate starting with req0
        drive_req(0, 1'b0, 32'hffff_fff9, 64'd1234, unit_calc(1'b0, 32'hffff_fff9, 64'd1234), 1'b0);
        drive_req(1, 1'b1, 32'd13, 64'hffff_ffff_ffff_fc00, unit_calc(1'b1, 32'd13, 64'hffff_ffff_ffff_fc00), 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_for("t3_ack", 4, 20, t_ack);
            who = ack1 ? 1 : 0;
            check("t3_ack_order", 66'(who), 66'(k % 2));
            if (k < 2) begin
                rop = 1'($urandom_range(0, 1));
                ra  = $urandom_range(1, 5000);
                if ($urandom_range(0, 1) == 1) ra = -ra;
                rb  = {$urandom, $urandom};
                drive_req(who, rop, ra, rb, unit_calc(rop, ra, rb), 1'b0);
            end else if (who == 0) begin
                req0 = 1'b0;
            end else begin
                req1 = 1'b0;
            end
            wait_for("t3_done", 5, 80, t_done);
            check("t3_latency", 66'(t_done - t_ack), 66'(LAT_ACK_DONE));
        end
        @(negedge clock);

        // 4: unit never answers -> timeout 48 cycles after entering WAIT
        stuck_mode = 1'b1;
        drive_req(0, 1'b0, 32'd9, 64'd9, 64'd0, 1'b1);
        wait_for("t4_ack0", 0, 10, t_ack);
        req0 = 1'b0;
        wait_for("t4_done0", 2, 90, t_done);
        check("t4_timeout_cycles", 66'(t_done - t_ack), 66'(2 + 48));
        @(negedge clock);
        check("t4_idle", {65'd0, busy}, 66'd0);
        stuck_mode = 1'b0;

        // 5: valid left high and not cleared -> accepted only once MIN_LAT has elapsed
        drive_req(1, 1'b0, 32'd6, 64'd7, 64'd42, 1'b0);
        wait_for("t5_ack1", 1, 10, t_ack);
        req1 = 1'b0;
        wait_for("t5_done1", 3, 80, t_done);
        @(negedge clock);
        stale_mode = 1'b1;
        drive_req(0, 1'b0, 32'd100, 64'd100, 64'd42, 1'b0);
        wait_for("t5_ack0", 0, 10, t_ack);
        req0 = 1'b0;
        wait_for("t5_stale_done0", 2, 20, t_done);
        check("t5_min_lat_cycles", 66'(t_done - t_ack), 66'(2 + 2 + 1));
        @(negedge clock);
        stale_mode = 1'b0;

        // 6: reset in WAIT discards the operation; last_grant returns to 1
        drive_req(0, 1'b0, 32'd11, 64'd11, 64'd121, 1'b0);
        wait_for("t6_ack0", 0, 10, t_ack);
        req0 = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("t6_rst_ctrl_outs", zero_outs(), 66'd0);
        check("t6_rst_res", {2'd0, res}, 66'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (done0 || done1) dones++;
        end
        check("t6_no_done_after_reset", 66'(dones), 66'd0);
        drive_req(0, 1'b0, 32'd2, 64'd21, 64'd42, 1'b0);
        drive_req(1, 1'b1, 32'd5, 64'd27, {32'd2, 32'd5}, 1'b0);
        wait_for("t6_tie_ack", 4, 10, t_ack);
        check("t6_tie_winner", {64'd0, ack1, ack0}, 66'd1);
        req0 = 1'b0;
        wait_for("t6_done0", 2, 80, t_done);
        wait_for("t6_ack1", 1, 10, t_ack);
        req1 = 1'b0;
        wait_for("t6_done1", 3, 80, t_done);
        repeat (3) @(negedge clock);
        check("sb_queue_empty", 66'(exp_q.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
